pocket_video_sync: RTL and testbench



---
 rtl/pocket_video_sync.sv | 173 +++++++++++++++++
 tb/tb_pocket_video_sync.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pocket_video_sync.sv
// Pocket scaler video bus output stage: sync pulse shaping, DE/skip, blank RGB, active size measurement.
// Optional macro POCKET_SCALER_SLOT_EN puts the scaler slot index on vid_rgb during the VS cycle.
module pocket_video_sync #(
  parameter int DATA_W   = 8,
  parameter int HS_DELAY = 3
) (
  input  logic              clk_vid,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic [DATA_W-1:0] r_in,
  input  logic [DATA_W-1:0] g_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              hblank,
  input  logic              vblank,
  input  logic [2:0]        scaler_slot,
  output logic [23:0]       vid_rgb,
  output logic              vid_de,
  output logic              vid_hs,
  output logic              vid_vs,
  output logic              vid_skip,
  output logic [9:0]        h_active,
  output logic [9:0]        v_active
);

  localparam int GW = (HS_DELAY < 1) ? 1 : $clog2(HS_DELAY + 1);

  logic [7:0] rExp, gExp, bExp;

  // Narrow channels are widened by repeating their top bits into the low bits.
  generate
    if (DATA_W == 8) begin : gFull
      assign rExp = r_in;
      assign gExp = g_in;
      assign bExp = b_in;
    end else if (DATA_W < 8) begin : gNarrow
      assign rExp = {r_in, r_in[DATA_W-1 -: 8-DATA_W]};
      assign gExp = {g_in, g_in[DATA_W-1 -: 8-DATA_W]};
      assign bExp = {b_in, b_in[DATA_W-1 -: 8-DATA_W]};
    end else begin : gWide
      logic unusedLowBits;
      assign rExp = r_in[DATA_W-1 -: 8];
      assign gExp = g_in[DATA_W-1 -: 8];
      assign bExp = b_in[DATA_W-1 -: 8];
      assign unusedLowBits = ^{r_in[DATA_W-9:0], g_in[DATA_W-9:0], b_in[DATA_W-9:0]};
    end
  endgenerate

`ifndef POCKET_SCALER_SLOT_EN
  logic unusedSlot;
  assign unusedSlot = ^scaler_slot;
`endif

  logic          hsyncPrev_q, hsyncPrev_d;
  logic          vsyncPrev_q, vsyncPrev_d;
  logic          de_q, de_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          skip_q, skip_d;
  logic          pending_q, pending_d;
  logic [GW-1:0] guard_q, guard_d;
  logic [23:0]   rgb_q, rgb_d;
  logic [9:0]    wCnt_q, wCnt_d;
  logic [9:0]    lCnt_q, lCnt_d;
  logic [9:0]    hAct_q, hAct_d;
  logic [9:0]    vAct_q, vAct_d;

  logic deNow, vsEdge, hsEdge, deRise, deFall;

  assign deNow  = ~hblank & ~vblank;
  assign vsEdge = ce_pix & vsync & ~vsyncPrev_q;
  assign hsEdge = ce_pix & hsync & ~hsyncPrev_q;
  assign deRise = ce_pix & deNow & ~de_q;
  assign deFall = ce_pix & ~deNow & de_q;

  always_comb begin
    hsyncPrev_d = hsyncPrev_q;
    vsyncPrev_d = vsyncPrev_q;
    de_d        = de_q;
    hs_d        = 1'b0;
    vs_d        = 1'b0;
    skip_d      = de_q & ~ce_pix;
    pending_d   = pending_q;
    guard_d     = guard_q;
    rgb_d       = vs_q ? 24'h0 : rgb_q;
    wCnt_d      = wCnt_q;
    lCnt_d      = lCnt_q;
    hAct_d      = hAct_q;
    vAct_d      = vAct_q;

    if (ce_pix) begin
      hsyncPrev_d = hsync;
      vsyncPrev_d = vsync;
      de_d        = deNow;
      rgb_d       = deNow ? {rExp, gExp, bExp} : 24'h0;

      // VS always wins; any HS edge seen alongside it waits out the guard window.
      if (vsEdge) begin
        vs_d    = 1'b1;
        guard_d = GW'(HS_DELAY);
        if (hsEdge) pending_d = 1'b1;
`ifdef POCKET_SCALER_SLOT_EN
        rgb_d = {21'h0, scaler_slot};
`endif
      end else begin
        guard_d = (guard_q != '0) ? guard_q - GW'(1) : '0;
        if ((pending_q | hsEdge) && (guard_q <= GW'(1))) begin
          hs_d      = 1'b1;
          pending_d = 1'b0;
        end else if (hsEdge) begin
          pending_d = 1'b1;
        end
      end

      if (deFall) begin
        hAct_d = wCnt_q;
        wCnt_d = '0;
      end else if (deNow && (wCnt_q != 10'd1023)) begin
        wCnt_d = wCnt_q + 10'd1;
      end

      // A DE rise coinciding with VS belongs to the new frame.
      if (vsEdge) begin
        vAct_d = lCnt_q;
        lCnt_d = deRise ? 10'd1 : 10'd0;
      end else if (deRise && (lCnt_q != 10'd1023)) begin
        lCnt_d = lCnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      hsyncPrev_q <= 1'b0;
      vsyncPrev_q <= 1'b0;
      de_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      skip_q      <= 1'b0;
      pending_q   <= 1'b0;
      guard_q     <= '0;
      rgb_q       <= 24'h0;
      wCnt_q      <= 10'd0;
      lCnt_q      <= 10'd0;
      hAct_q      <= 10'd0;
      vAct_q      <= 10'd0;
    end else begin
      hsyncPrev_q <= hsyncPrev_d;
      vsyncPrev_q <= vsyncPrev_d;
      de_q        <= de_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      skip_q      <= skip_d;
      pending_q   <= pending_d;
      guard_q     <= guard_d;
      rgb_q       <= rgb_d;
      wCnt_q      <= wCnt_d;
      lCnt_q      <= lCnt_d;
      hAct_q      <= hAct_d;
      vAct_q      <= vAct_d;
    end
  end

  assign vid_rgb  = rgb_q;
  assign vid_de   = de_q;
  assign vid_hs   = hs_q;
  assign vid_vs   = vs_q;
  assign vid_skip = skip_q;
  assign h_active = hAct_q;
  assign v_active = vAct_q;

endmodule

// File: tb/tb_pocket_video_sync.sv
// Directed self-checking bench for pocket_video_sync (default 8-bit instance plus a 4-bit instance).
module tb_pocket_video_sync;

  logic        clk_vid = 1'b0;
  logic        reset = 1'b1;
  logic        ce_pix = 1'b0;
  logic [7:0]  r_in = '0, g_in = '0, b_in = '0;
  logic [3:0]  r4 = '0, g4 = '0, b4 = '0;
  logic        hsync = 1'b0, vsync = 1'b0, hblank = 1'b1, vblank = 1'b1;
  logic [2:0]  scaler_slot = '0;

  logic [23:0] vid_rgb, vid_rgb4;
  logic        vid_de, vid_hs, vid_vs, vid_skip;
  logic        vid_de4, vid_hs4, vid_vs4, vid_skip4;
  logic [9:0]  h_active, v_active, h_active4, v_active4;

  int checks = 0;
  int errors = 0;

  always #5 clk_vid = ~clk_vid;

  pocket_video_sync #(.DATA_W(8), .HS_DELAY(3)) dut (
    .clk_vid(clk_vid), .reset(reset), .ce_pix(ce_pix),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
    .scaler_slot(scaler_slot),
    .vid_rgb(vid_rgb), .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs),
    .vid_skip(vid_skip), .h_active(h_active), .v_active(v_active)
  );

  pocket_video_sync #(.DATA_W(4), .HS_DELAY(3)) dut4 (
    .clk_vid(clk_vid), .reset(reset), .ce_pix(ce_pix),
    .r_in(r4), .g_in(g4), .b_in(b4),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
    .scaler_slot(scaler_slot),
    .vid_rgb(vid_rgb4), .vid_de(vid_de4), .vid_hs(vid_hs4), .vid_vs(vid_vs4),
    .vid_skip(vid_skip4), .h_active(h_active4), .v_active(v_active4)
  );

  // One clock with the given enable; outputs are sampled 1ns after the edge.
  task automatic tick(input logic ce);
    ce_pix = ce;
    @(posedge clk_vid);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r_in = 8'($urandom); g_in = 8'($urandom); b_in = 8'($urandom);
      {hsync, vsync, hblank, vblank} = 4'($urandom);
      scaler_slot = 3'($urandom);
      tick(1'($urandom));
    end
    checks++;
    if ({vid_rgb, vid_de, vid_hs, vid_vs, vid_skip, h_active, v_active} !== 49'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got rgb=%h de=%b hs=%b vs=%b skip=%b h=%0d v=%0d, expected all 0",
               vid_rgb, vid_de, vid_hs, vid_vs, vid_skip, h_active, v_active);
    end
    reset = 1'b0;
    hsync = 1'b0; vsync = 1'b1; hblank = 1'b1; vblank = 1'b1;
    tick(1'b1);
    checks++;
    if (vid_vs !== 1'b1 || vid_hs !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_first_vs: got vs=%b hs=%b, expected vs=1 hs=0", vid_vs, vid_hs);
    end
    checks++;
    if (v_active !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset_v_active: got %0d, expected 0", v_active);
    end
  endtask

  task automatic test_width_height();
    logic [7:0] pv;
    vsync = 1'b0; hblank = 1'b1; vblank = 1'b1;
    tick(1'b1); tick(1'b0);
    vsync = 1'b1;
    tick(1'b1);
    checks++;
    if (vid_vs !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wh_start_vs: got %b, expected 1", vid_vs);
    end
    tick(1'b0);
    checks++;
    if (vid_vs !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wh_vs_one_cycle: got %b, expected 0", vid_vs);
    end
    vsync = 1'b0; vblank = 1'b0;
    for (int line = 0; line < 240; line++) begin
      hblank = 1'b0;
      for (int p = 0; p < ((line == 239) ? 320 : 4); p++) begin
        pv = p[7:0];
        r_in = pv; g_in = ~pv; b_in = 8'h5A;
        tick(1'b1);
        if (line == 239) begin
          checks++;
          if (vid_de !== 1'b1 || vid_rgb !== {pv, ~pv, 8'h5A}) begin
            errors++;
            $display("[TB] FAIL wh_pixel %0d: got de=%b rgb=%h, expected de=1 rgb=%h",
                     p, vid_de, vid_rgb, {pv, ~pv, 8'h5A});
          end
        end
        tick(1'b0);
        if (line == 239) begin
          checks++;
          if (vid_skip !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wh_skip %0d: got %b, expected 1", p, vid_skip);
          end
        end
      end
      hblank = 1'b1;
      tick(1'b1);
      if (line == 239) begin
        checks++;
        if (h_active !== 10'd320 || vid_de !== 1'b0 || vid_rgb !== 24'h0) begin
          errors++;
          $display("[TB] FAIL wh_h_active: got h=%0d de=%b rgb=%h, expected h=320 de=0 rgb=0",
                   h_active, vid_de, vid_rgb);
        end
      end
      tick(1'b0);
      checks++;
      if (vid_skip !== 1'b0) begin
        errors++;
        $display("[TB] FAIL wh_skip_blank: got %b, expected 0", vid_skip);
      end
      tick(1'b1); tick(1'b0);
    end
    vblank = 1'b1; vsync = 1'b1;
    tick(1'b1);
    checks++;
    if (vid_vs !== 1'b1 || v_active !== 10'd240 || h_active !== 10'd320) begin
      errors++;
      $display("[TB] FAIL wh_v_active: got vs=%b v=%0d h=%0d, expected vs=1 v=240 h=320",
               vid_vs, v_active, h_active);
    end
    tick(1'b0);
  endtask

  task automatic test_hs_guard();
    vsync = 1'b0; hsync = 1'b0; hblank = 1'b1; vblank = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b1);
    vsync = 1'b1;
    tick(1'b1);
    checks++;
    if (vid_vs !== 1'b1 || vid_hs !== 1'b0) begin
      errors++;
      $display("[TB] FAIL guard_vs: got vs=%b hs=%b, expected vs=1 hs=0", vid_vs, vid_hs);
    end
    for (int k = 1; k <= 6; k++) begin
      if (k == 1) hsync = 1'b1;
      tick(1'b1);
      checks++;
      if (vid_hs !== (k == 3) || vid_vs !== 1'b0) begin
        errors++;
        $display("[TB] FAIL guard_hs pixel %0d: got hs=%b vs=%b, expected hs=%b vs=0",
                 k, vid_hs, vid_vs, (k == 3));
      end
      tick(1'b0);
      checks++;
      if (vid_hs !== 1'b0) begin
        errors++;
        $display("[TB] FAIL guard_hs_nonpixel %0d: got %b, expected 0", k, vid_hs);
      end
    end
  endtask

  task automatic test_collision();
    vsync = 1'b0; hsync = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b1);
    vsync = 1'b1; hsync = 1'b1;
    tick(1'b1);
    checks++;
    if (vid_vs !== 1'b1 || vid_hs !== 1'b0) begin
      errors++;
      $display("[TB] FAIL collide_vs: got vs=%b hs=%b, expected vs=1 hs=0", vid_vs, vid_hs);
    end
    for (int k = 1; k <= 7; k++) begin
      if (k == 1) hsync = 1'b0;
      if (k == 2) hsync = 1'b1;
      tick(1'b1);
      checks++;
      if (vid_hs !== (k == 3) || vid_vs !== 1'b0) begin
        errors++;
        $display("[TB] FAIL collide_hs pixel %0d: got hs=%b vs=%b, expected hs=%b vs=0",
                 k, vid_hs, vid_vs, (k == 3));
      end
    end
    hsync = 1'b0;
  endtask

  task automatic test_slot();
    logic [23:0] expSlot;
`ifdef POCKET_SCALER_SLOT_EN
    expSlot = 24'h000005;
`else
    expSlot = 24'h000000;
`endif
    vsync = 1'b0; hblank = 1'b1; vblank = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b1);
    scaler_slot = 3'd5;
    vsync = 1'b1;
    tick(1'b1);
    checks++;
    if (vid_vs !== 1'b1 || vid_rgb !== expSlot) begin
      errors++;
      $display("[TB] FAIL slot_word: got vs=%b rgb=%h, expected vs=1 rgb=%h", vid_vs, vid_rgb, expSlot);
    end
    tick(1'b0);
    checks++;
    if (vid_rgb !== 24'h0) begin
      errors++;
      $display("[TB] FAIL slot_after_nonpixel: got %h, expected 000000", vid_rgb);
    end
    tick(1'b1);
    checks++;
    if (vid_rgb !== 24'h0) begin
      errors++;
      $display("[TB] FAIL slot_after_pixel: got %h, expected 000000", vid_rgb);
    end
  endtask

  task automatic test_saturation();
    r4 = 4'hA; g4 = 4'h3; b4 = 4'hF;
    hblank = 1'b0; vblank = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      tick(1'b1);
      if (i == 0 || i == 1099) begin
        checks++;
        if (vid_rgb4 !== 24'hAA33FF) begin
          errors++;
          $display("[TB] FAIL sat_expand %0d: got %h, expected AA33FF", i, vid_rgb4);
        end
      end
    end
    hblank = 1'b1;
    tick(1'b1);
    checks++;
    if (h_active4 !== 10'd1023 || h_active !== 10'd1023) begin
      errors++;
      $display("[TB] FAIL sat_h_active: got h4=%0d h=%0d, expected 1023", h_active4, h_active);
    end
    for (int i = 0; i < 3; i++) begin
      tick(i[0] ? 1'b1 : 1'b0);
      checks++;
      if (vid_rgb4 !== 24'h0 || vid_rgb !== 24'h0) begin
        errors++;
        $display("[TB] FAIL sat_blank_rgb %0d: got rgb4=%h rgb=%h, expected 0", i, vid_rgb4, vid_rgb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_width_height();
    test_hs_guard();
    test_collision();
    test_slot();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
